// File: rtl/lsu.sv
// Load/store unit: accepts an execute result, issues one aligned memory access,
// formats byte/half/word data, and returns the result or an error to writeback.
module lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] EXU_data,
    input  logic [31:0] gpr_rdata2_in,
    input  logic        lsu_ren,
    input  logic        lsu_wen,
    input  logic [2:0]  lsu_op,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] LSU_data,
    output logic        lsu_err
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  op_q;
    logic        ren_q;
    logic        wen_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [31:0] result_q;
    logic        err_q;

    // op[1:0]: 00 byte, 01 half, anything else word; op[2] selects zero-extension
    function automatic logic misaligned(input logic [2:0] op, input logic [1:0] a);
        case (op[1:0])
            2'b00:   return 1'b0;
            2'b01:   return a[0];
            default: return (a != 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] store_mask(input logic [2:0] op, input logic [1:0] a);
        case (op[1:0])
            2'b00:   return 4'b0001 << a;
            2'b01:   return 4'b0011 << a;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] op, input logic [31:0] d);
        case (op[1:0])
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] load_fmt(input logic [2:0] op, input logic [1:0] a,
                                             input logic [31:0] rd);
        logic [31:0] sh;
        sh = rd >> {a, 3'b000};
        case (op[1:0])
            2'b00:   return {{24{~op[2] & sh[7]}}, sh[7:0]};
            2'b01:   return {{16{~op[2] & sh[15]}}, sh[15:0]};
            default: return sh;
        endcase
    endfunction

    assign cnt_d     = cnt_q + {{(CW-1){1'b0}}, 1'b1};
    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_RESP);
    assign mem_req   = (state_q == S_REQ);
    assign mem_we    = mem_req & wen_q & ~ren_q;
    assign mem_addr  = mem_req ? {addr_q[31:2], 2'b00} : 32'h0000_0000;
    assign mem_wdata = mem_we ? store_data(op_q, wdata_q) : 32'h0000_0000;
    assign mem_wmask = mem_we ? store_mask(op_q, addr_q[1:0]) : 4'b0000;
    assign LSU_data  = result_q;
    assign lsu_err   = err_q;

    // Request FSM with latched request fields, timeout counter and result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            addr_q   <= 32'h0000_0000;
            wdata_q  <= 32'h0000_0000;
            op_q     <= 3'b000;
            ren_q    <= 1'b0;
            wen_q    <= 1'b0;
            cnt_q    <= {CW{1'b0}};
            result_q <= 32'h0000_0000;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        addr_q  <= EXU_data;
                        wdata_q <= gpr_rdata2_in;
                        op_q    <= lsu_op;
                        ren_q   <= lsu_ren;
                        wen_q   <= lsu_wen;
                        if (!(lsu_ren || lsu_wen)) begin
                            result_q <= EXU_data;
                            err_q    <= 1'b0;
                            state_q  <= S_RESP;
                        end else if (misaligned(lsu_op, EXU_data[1:0])) begin
                            result_q <= 32'h0000_0000;
                            err_q    <= 1'b1;
                            state_q  <= S_RESP;
                        end else begin
                            cnt_q   <= {CW{1'b0}};
                            state_q <= S_REQ;
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_REQ: begin
                    // an ack on the final counted cycle still wins over the timeout
                    if (mem_ack) begin
                        result_q <= ren_q ? load_fmt(op_q, addr_q[1:0], mem_rdata) : 32'h0000_0000;
                        err_q    <= 1'b0;
                        state_q  <= S_RESP;
                    end else if (cnt_d == CW'(TIMEOUT_CYCLES)) begin
                        cnt_q    <= cnt_d;
                        result_q <= 32'h0000_0000;
                        err_q    <= 1'b1;
                        state_q  <= S_RESP;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                S_RESP: begin
                    if (out_ready) begin
                        state_q <= S_IDLE;
                    end else begin
                        state_q <= S_RESP;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: maximum number of cycles mem_req stays high without mem_ack before the access is aborted.
REQ-002 clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 in_valid  input  1  upstream execute result valid.
REQ-005 in_ready  output  1  lsu can accept a new request; equals 1 exactly in IDLE.
REQ-006 EXU_data  input  32  execute result; the effective address when a load or store is requested.
REQ-007 gpr_rdata2_in  input  32  store data, taken from the low bits.
REQ-008 lsu_ren  input  1  load request.
REQ-009 lsu_wen  input  1  store request; lsu_ren=lsu_wen=1 is treated as a load.
REQ-010 lsu_op  input  3  access size and sign, RISC-V funct3 encoding:
- 000 byte signed, 001 half signed, 010 word;
- 100 byte unsigned, 101 half unsigned;
- other codes decode as word.
REQ-011 mem_req  output  1  memory request, held until mem_ack.
REQ-012 mem_we  output  1  1 for store, 0 for load.
REQ-013 mem_addr  output  32  word-aligned address: {EXU_data[31:2],2'b00}.
REQ-014 mem_wdata  output  32  store data shifted to its byte lane.
REQ-015 mem_wmask  output  4  byte enables; 4'b0000 on loads.
REQ-016 mem_ack  input  1  request completes this cycle; for loads mem_rdata is valid in the same cycle.
REQ-017 mem_rdata  input  32  load data word.
REQ-018 out_valid  output  1  result valid to writeback.
REQ-019 out_ready  input  1  writeback accepts the result.
REQ-020 LSU_data  output  32  result: loaded value, or EXU_data passed through.
REQ-021 lsu_err  output  1  access was misaligned or timed out; qualified by out_valid.

Function
REQ-022 The FSM SHALL have states IDLE, REQ and RESP.
REQ-023 Request acceptance SHALL occur when in_valid and in_ready are both 1; at acceptance the block SHALL latch EXU_data, gpr_rdata2_in, lsu_op, lsu_ren and lsu_wen into internal registers.
REQ-024 Accepted request with neither lsu_ren nor lsu_wen SHALL go IDLE->RESP with LSU_data=EXU_data and lsu_err=0; latency is 1 cycle.
REQ-025 Misaligned access SHALL go IDLE->RESP with lsu_err=1 and LSU_data=0, and mem_req SHALL never be asserted. Misaligned means:
- half with addr[0]=1;
- word with addr[1:0]!=0.
REQ-026 Aligned load or store SHALL go IDLE->REQ; in REQ, mem_req=1 and mem_addr, mem_we, mem_wdata and mem_wmask SHALL be driven from the latched values and held stable.
REQ-027 REQ->RESP SHALL occur on the cycle mem_ack=1, including the first REQ cycle; a load SHALL capture its result in that same cycle.
REQ-028 Store lane formatting:
- byte: mask 4'b0001<<addr[1:0], wdata = byte replicated 4x;
- half: mask 4'b0011<<addr[1:0], wdata = half replicated 2x;
- word: mask 4'b1111.
REQ-029 Load formatting: shift mem_rdata right by 8*addr[1:0], then sign- or zero-extend the byte or half per lsu_op.
REQ-030 A store's result SHALL be LSU_data=0 with lsu_err=0.
REQ-031 The timeout counter SHALL clear on entry to REQ and increment each REQ cycle without mem_ack; when it reaches TIMEOUT_CYCLES, the FSM SHALL go to RESP with lsu_err=1, LSU_data=0 and mem_req deasserted.
REQ-032 mem_ack arriving in the same cycle the counter reaches TIMEOUT_CYCLES SHALL complete normally with lsu_err=0.
REQ-033 In RESP, out_valid=1 and LSU_data and lsu_err SHALL be held stable until out_ready=1; RESP->IDLE SHALL follow the handshake cycle.
REQ-034 There SHALL be no same-cycle re-acceptance: in_ready is 0 in RESP.
REQ-035 mem_ack outside REQ SHALL be ignored.

Reset
REQ-036 When rst_n=0 at a clock edge, the state SHALL become IDLE, the counter 0, and all latched registers 0.
REQ-037 During and after reset the outputs SHALL be: mem_req=0, mem_we=0, mem_wmask=0, mem_addr=0, mem_wdata=0, out_valid=0, LSU_data=0, lsu_err=0; in_ready=1 from the first cycle after reset release.
REQ-038 Reset in REQ or RESP SHALL abandon the transaction, and any later mem_ack for it SHALL be ignored.

Verification
REQ-039 Pass-through: EXU_data=0x1234_5678, no ren/wen -> out_valid=1 next cycle, LSU_data=0x1234_5678, mem_req never high.
REQ-040 Signed byte load: addr 0x8000_0003, lsu_op=000, mem_ack after 3 cycles with rdata 0x80AA_BBCC -> mem_addr 0x8000_0000, LSU_data 0xFFFF_FF80.
REQ-041 Half store: addr 0x8000_0002, gpr_rdata2_in=0xDEAD_BEEF, lsu_op=001 -> mem_wmask 4'b1100, mem_wdata 0xBEEF_BEEF, mem_we=1, result LSU_data=0.
REQ-042 Misaligned word load: addr 0x8000_0001 -> lsu_err=1 next cycle, mem_req never asserted.
REQ-043 Timeout with TIMEOUT_CYCLES=4 and no mem_ack -> mem_req high 4 cycles, then out_valid=1, lsu_err=1; with out_ready=0 for 5 cycles, outputs are held.
REQ-044 Reset mid-REQ: rst_n=0 for 1 cycle, then mem_ack=1 -> mem_req=0, out_valid stays 0, in_ready=1.
